hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL take parameter AW, default 5, giving the register-address width (2**AW architectural registers).
REQ-002 The block SHALL take parameter LOAD_LAT, default 2, giving the extra cycles a load takes beyond an ALU op, range 0..6.
REQ-003 The block SHALL take parameter MDU_LAT, default 8, giving the multiply/divide latency in cycles, range 2..15.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 id_valid  input  1  the ID stage holds a real instruction.
REQ-007 id_rs, id_rt  input  AW each  source register addresses.
REQ-008 id_rs_used, id_rt_used  input  1 each  the source is actually read.
REQ-009 id_branch  input  1  the instruction resolves in ID and needs its operands there.
REQ-010 id_we, id_dst  input  1 / AW  the instruction writes register id_dst.
REQ-011 id_kind  input  2  latency class: 0 ALU, 1 LOAD, 2 MDU, 3 reserved (treated as ALU).
REQ-012 id_hilo_rd  input  1  the instruction reads HI/LO (mfhi/mflo).
REQ-013 branch_taken  input  1  the branch or jump in ID is taken.
REQ-014 pc_stall, if_id_stall  output  1 each  freeze PC and IF/ID.
REQ-015 id_ex_flush  output  1  insert a bubble into ID/EX.
REQ-016 if_id_flush  output  1  squash the fetched instruction.
REQ-017 mdu_busy  output  1  the MDU is occupied.

Function
REQ-018 The block SHALL hold a counter cnt[r] of 4 bits for each register r=1..2**AW-1; register 0 SHALL never be tracked and SHALL always read as cnt=0.
REQ-019 The issue latency L(kind) SHALL be 1 for ALU, 1+LOAD_LAT for LOAD, and MDU_LAT for MDU.
REQ-020 The block SHALL define issue = id_valid & ~stall & id_we & (id_dst!=0).
REQ-021 Each cycle, every nonzero cnt SHALL decrement by 1, saturating at 0.
REQ-022 On issue, cnt[id_dst] SHALL load max(cnt[id_dst]-1, L(id_kind)) so that a WAW case never shortens the wait.
REQ-023 raw_stall SHALL be asserted for a used source s when cnt[s]>1, or when id_branch=1 and cnt[s]>0.
REQ-024 mdu_stall SHALL be asserted when id_valid & mdu_busy & (id_kind==2 | id_hilo_rd).
REQ-025 The block SHALL define stall = id_valid & (raw_stall | mdu_stall).
REQ-026 The stall outputs SHALL be combinational from registered state and current inputs: pc_stall = if_id_stall = id_ex_flush = stall.
REQ-027 if_id_flush SHALL equal branch_taken & id_valid & ~stall; when a stall coincides with a taken branch, the stall wins, no flush occurs, and the branch re-evaluates next cycle.
REQ-028 The MDU busy counter SHALL load MDU_LAT-1 on an MDU-kind issue and otherwise decrement to 0; mdu_busy SHALL equal (counter!=0).
REQ-029 A stalled instruction SHALL NOT update any counter.
REQ-030 With id_valid=0, every output except mdu_busy SHALL be 0.

Reset
REQ-031 Asserting rst SHALL asynchronously clear all cnt entries and the MDU counter.
REQ-032 Reset applied mid-operation SHALL discard all pending hazards; the first cycle after release behaves as an empty scoreboard.
REQ-033 After reset, all outputs SHALL be 0 while id_valid=0.

Structure
REQ-034 The shared defines package SHALL hold the KIND_ALU/LOAD/MDU encodings and the counter width constant.
REQ-035 The MDU busy counter SHALL be a single sub-module, busy_timer, with parameter MDU_LAT.
REQ-036 The register table SHALL be a flat flop array, not a RAM, so that two sources can be read in the same cycle.

Verification
REQ-037 LOAD to r5 (LOAD_LAT=2), next instruction reads r5 -> stall high for exactly 2 cycles, then released.
REQ-038 ALU write to r3, next instruction is a branch reading r3 -> 1 stall cycle; a non-branch reader sees 0 stall cycles.
REQ-039 MDU issue (MDU_LAT=8), then mflo on the next cycle -> stall for 7 cycles and mdu_busy high for 7 cycles.
REQ-040 MDU write to r4, then ALU write to r4 one cycle later, then a reader of r4 -> the wait follows the MDU latency, not 1.
REQ-041 branch_taken together with a RAW stall -> if_id_flush=0 that cycle; if_id_flush=1 on the first unstalled cycle.
REQ-042 Issue LOAD to r7, assert rst the next cycle, then a reader of r7 after release -> no stall.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module  : hazard_scoreboard_pkg
// Purpose : Shared latency-class encodings and counter width for the
//           hazard scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_MDU  = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  // Cycles until a result can be consumed from the EX-forwarding point;
  // the reserved class behaves like a plain ALU op.
  function automatic logic [CNT_W-1:0] issue_lat(input logic [1:0] kind,
                                                 input int load_lat,
                                                 input int mdu_lat);
    case (kind_e'(kind))
      KIND_LOAD: issue_lat = CNT_W'(1 + load_lat);
      KIND_MDU:  issue_lat = CNT_W'(mdu_lat);
      default:   issue_lat = CNT_W'(1);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_busy_timer.sv
// ============================================================================
// Module  : busy_timer
// Purpose : Down-counter that marks the multiply/divide unit occupied.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module busy_timer
  import hazard_scoreboard_pkg::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= CNT_W'(MDU_LAT - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign busy = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Per-register result-latency scoreboard producing ID-stage
//           stall and flush controls for an in-order pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 2,
  parameter int MDU_LAT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          id_branch,
  input  logic          id_we,
  input  logic [AW-1:0] id_dst,
  input  logic [1:0]    id_kind,
  input  logic          id_hilo_rd,
  input  logic          branch_taken,
  output logic          pc_stall,
  output logic          if_id_stall,
  output logic          id_ex_flush,
  output logic          if_id_flush,
  output logic          mdu_busy
);

  localparam int NREG = 2 ** AW;

  logic [CNT_W-1:0] w_cnt [NREG];
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] w_rs_cnt;
  logic [CNT_W-1:0] w_rt_cnt;
  logic             w_rs_haz;
  logic             w_rt_haz;
  logic             w_mdu_stall;
  logic             w_stall;
  logic             w_issue;

  assign w_lat    = issue_lat(id_kind, LOAD_LAT, MDU_LAT);
  assign w_cnt[0] = '0;

  // Flat flop table so both sources are readable in the same cycle.
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_dec;

    assign w_dec = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_issue && (id_dst == AW'(r))) begin
        // A later writer never shortens an older in-flight write (WAW).
        r_cnt <= (w_dec > w_lat) ? w_dec : w_lat;
      end else begin
        r_cnt <= w_dec;
      end
    end

    assign w_cnt[r] = r_cnt;
  end

  assign w_rs_cnt = w_cnt[id_rs];
  assign w_rt_cnt = w_cnt[id_rt];

  // Branches resolve in ID, so they also wait out the last forwardable cycle.
  assign w_rs_haz = id_rs_used &
                    ((w_rs_cnt > CNT_W'(1)) | (id_branch & (w_rs_cnt != '0)));
  assign w_rt_haz = id_rt_used &
                    ((w_rt_cnt > CNT_W'(1)) | (id_branch & (w_rt_cnt != '0)));

  assign w_mdu_stall = id_valid & mdu_busy & ((id_kind == KIND_MDU) | id_hilo_rd);
  assign w_stall     = id_valid & (w_rs_haz | w_rt_haz | w_mdu_stall);
  assign w_issue     = id_valid & ~w_stall & id_we & (id_dst != '0);

  busy_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_busy_timer (
    .clk   (clk),
    .rst   (rst),
    .start (w_issue & (id_kind == KIND_MDU)),
    .busy  (mdu_busy)
  );

  assign pc_stall    = w_stall;
  assign if_id_stall = w_stall;
  assign id_ex_flush = w_stall;
  assign if_id_flush = branch_taken & id_valid & ~w_stall;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module  : tb_hazard_scoreboard
// Purpose : Self-checking bench for hazard_scoreboard using a ready-cycle
//           reference model, directed scenarios and random traffic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int AW       = 5;
  localparam int LOAD_LAT = 2;
  localparam int MDU_LAT  = 8;
  localparam int NREG     = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic          id_rs_used = 1'b0;
  logic          id_rt_used = 1'b0;
  logic          id_branch = 1'b0;
  logic          id_we = 1'b0;
  logic [AW-1:0] id_dst = '0;
  logic [1:0]    id_kind = '0;
  logic          id_hilo_rd = 1'b0;
  logic          branch_taken = 1'b0;
  logic          pc_stall;
  logic          if_id_stall;
  logic          id_ex_flush;
  logic          if_id_flush;
  logic          mdu_busy;

  hazard_scoreboard #(
    .AW       (AW),
    .LOAD_LAT (LOAD_LAT),
    .MDU_LAT  (MDU_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_branch    (id_branch),
    .id_we        (id_we),
    .id_dst       (id_dst),
    .id_kind      (id_kind),
    .id_hilo_rd   (id_hilo_rd),
    .branch_taken (branch_taken),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_flush  (id_ex_flush),
    .if_id_flush  (if_id_flush),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  // Model: absolute cycle at which each register's result is fully settled,
  // and the first cycle on which the MDU is free again.
  int now;
  int ready [NREG];
  int mdu_free;
  int n_tests;
  int n_fail;
  logic last_stall;
  logic last_flush;
  logic last_busy;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, now);
    end
  endtask

  function automatic int left(input int r);
    if (r == 0 || ready[r] <= now) return 0;
    return ready[r] - now;
  endfunction

  function automatic int lat_of(input int kind);
    if (kind == 1) return 1 + LOAD_LAT;
    if (kind == 2) return MDU_LAT;
    return 1;
  endfunction

  function automatic logic src_haz(input logic used, input int r);
    return used && (left(r) > 1 || (id_branch && left(r) > 0));
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    mdu_free = 0;
  endtask

  task automatic set_instr(input logic v, input int rs, input logic rsu,
                           input int rt, input logic rtu, input logic br,
                           input logic we, input int dst, input int kind,
                           input logic hilo, input logic taken);
    id_valid     = v;
    id_rs        = AW'(rs);
    id_rs_used   = rsu;
    id_rt        = AW'(rt);
    id_rt_used   = rtu;
    id_branch    = br;
    id_we        = we;
    id_dst       = AW'(dst);
    id_kind      = 2'(kind);
    id_hilo_rd   = hilo;
    branch_taken = taken;
  endtask

  task automatic idle(input int n);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic busy_e, stall_e, flush_e, issue_e;
    @(negedge clk);
    busy_e  = (mdu_free > now);
    stall_e = id_valid && (src_haz(id_rs_used, int'(id_rs)) ||
                           src_haz(id_rt_used, int'(id_rt)) ||
                           (busy_e && (id_kind == 2'd2 || id_hilo_rd)));
    flush_e = branch_taken && id_valid && !stall_e;
    issue_e = id_valid && !stall_e && id_we && (id_dst != '0);
    check_eq("pc_stall",    int'(pc_stall),    int'(stall_e));
    check_eq("if_id_stall", int'(if_id_stall), int'(stall_e));
    check_eq("id_ex_flush", int'(id_ex_flush), int'(stall_e));
    check_eq("if_id_flush", int'(if_id_flush), int'(flush_e));
    check_eq("mdu_busy",    int'(mdu_busy),    int'(busy_e));
    last_stall = pc_stall;
    last_flush = if_id_flush;
    last_busy  = mdu_busy;
    @(posedge clk);
    if (issue_e) begin
      int t;
      t = now + 1 + lat_of(int'(id_kind));
      if (t > ready[int'(id_dst)]) ready[int'(id_dst)] = t;
      if (id_kind == 2'd2) mdu_free = now + MDU_LAT;
    end
    now++;
    #1;
  endtask

  // Hold the current instruction until it is released; bounded.
  task automatic hold(output int stalls, output int busy_cycles);
    stalls = 0;
    busy_cycles = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (last_busy) busy_cycles++;
      if (!last_stall) return;
      stalls++;
    end
    check_eq("hold_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #2;
    check_eq("rst_mdu_busy", int'(mdu_busy), 0);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    int ns, nb;
    now = 0;
    n_tests = 0;
    n_fail = 0;
    clear_model();

    // Reset state with no instruction present.
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset_pc_stall", int'(pc_stall), 0);
    check_eq("reset_flush",    int'(if_id_flush), 0);
    check_eq("reset_busy",     int'(mdu_busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // LOAD r5 then reader of r5: two stall cycles.
    set_instr(1, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    set_instr(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); hold(ns, nb);
    check_eq("load_use_stalls", ns, 2);
    idle(4);

    // ALU r3 then branch reader: one stall cycle.
    set_instr(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0); cycle();
    set_instr(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0); hold(ns, nb);
    check_eq("alu_branch_stalls", ns, 1);
    // ALU r3 then non-branch reader: no stall.
    set_instr(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0); cycle();
    set_instr(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); hold(ns, nb);
    check_eq("alu_use_stalls", ns, 0);
    idle(2);

    // MDU issue then mflo: seven stall cycles with the MDU busy throughout.
    set_instr(1, 0, 0, 0, 0, 0, 1, 9, 2, 0, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 0, 1, 10, 0, 1, 0); hold(ns, nb);
    check_eq("mflo_stalls", ns, 7);
    check_eq("mflo_busy_cycles", nb, 7);
    idle(10);

    // WAW: MDU r4 then ALU r4, reader waits on the MDU result.
    set_instr(1, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0); cycle();
    set_instr(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0); hold(ns, nb);
    check_eq("waw_stalls", ns, 6);
    idle(10);

    // Taken branch under a RAW stall: flush only once released.
    set_instr(1, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0); cycle();
    set_instr(1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 1); cycle();
    check_eq("branch_stalled_flush", int'(last_flush), 0);
    hold(ns, nb);
    check_eq("branch_release_flush", int'(last_flush), 1);
    idle(4);

    // Reset mid-flight discards the pending LOAD and MDU hazards.
    set_instr(1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0); cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    set_instr(1, 7, 1, 8, 1, 1, 0, 0, 0, 1, 0); cycle();
    check_eq("post_reset_stall", int'(last_stall), 0);
    idle(2);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      set_instr(($urandom_range(0, 9) != 0),
                int'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, 7)), 1'($urandom),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0),
                1'($urandom));
      cycle();
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
